// File: rtl/mult_pkg.sv
// mult_m shared constants and element slicing helper.
// Matrices are 5x5 signed bytes packed row-major, MSB first.
package mult_pkg;

    localparam int N     = 5;
    localparam int W     = 8;
    localparam int ACC_W = 18;
    localparam int MAT_W = N * N * W;

    localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(127);
    localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_W'(-128);

    // MSB bit position of element (i,j) inside a packed matrix.
    function automatic int off(input int i, input int j);
        return MAT_W - 1 - W * (N * i + j);
    endfunction

endpackage

// File: rtl/mult_m_if.sv
// mult_m matrix bus: operands in, registered product out.
// No handshake; operands are sampled on every clock edge.
interface mult_m_if;
    import mult_pkg::*;

    logic [MAT_W-1:0] lin;
    logic [MAT_W-1:0] col;
    logic [MAT_W-1:0] n_out;
    logic             ovf;

    modport master (
        output lin,
        output col,
        input  n_out,
        input  ovf
    );

    modport slave (
        input  lin,
        input  col,
        output n_out,
        output ovf
    );

endinterface

// File: rtl/dot5_s8.sv
// dot5_s8: 5-term signed byte dot product, full-width accumulate.
// Returns the low byte plus a flag when the sum leaves byte range.
module dot5_s8
    import mult_pkg::*;
(
    input  logic [N*W-1:0] a,
    input  logic [N*W-1:0] b,
    output logic [W-1:0]   y,
    output logic           ov
);

    logic signed [ACC_W-1:0] acc;
    logic signed [W-1:0]     ak;
    logic signed [W-1:0]     bk;
    logic signed [2*W-1:0]   p;

    // Term 0 sits in the top byte; products are exact 16-bit values.
    always_comb begin
        acc = '0;
        ak  = '0;
        bk  = '0;
        p   = '0;
        for (int k = 0; k < N; k++) begin
            ak  = a[(N-1-k)*W +: W];
            bk  = b[(N-1-k)*W +: W];
            p   = (2*W)'(ak) * (2*W)'(bk);
            acc = acc + ACC_W'(p);
        end
    end

    assign y  = acc[W-1:0];
    assign ov = (acc > ACC_MAX) || (acc < ACC_MIN);

endmodule

// File: rtl/mult_m.sv
// mult_m: registered 5x5 signed byte matrix product, 1-cycle latency.
// Product bytes wrap; ovf marks any element outside byte range.
module mult_m
    import mult_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    mult_m_if.slave bus
);

    logic [MAT_W-1:0] c_all;
    logic [N*N-1:0]   ov_all;
    logic [MAT_W-1:0] n_out_q;
    logic             ovf_q;

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            localparam int OC = off(i, j);
            logic [N*W-1:0] a_row;
            logic [N*W-1:0] b_col;
            logic [W-1:0]   y;
            logic           ov;

            assign a_row = bus.lin[off(i, 0) -: N*W];

            for (genvar k = 0; k < N; k++) begin : g_k
                localparam int OB = off(k, j);
                assign b_col[(N-1-k)*W +: W] = bus.col[OB -: W];
            end

            dot5_s8 u_dot (
                .a  (a_row),
                .b  (b_col),
                .y  (y),
                .ov (ov)
            );

            assign c_all[OC -: W]    = y;
            assign ov_all[N*i + j]   = ov;
        end
    end

    // Capture the product and its overflow summary every edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            n_out_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            n_out_q <= c_all;
            ovf_q   <= |ov_all;
        end
    end

    assign bus.n_out = n_out_q;
    assign bus.ovf   = ovf_q;

endmodule

// File: tb/tb_mult_m.sv
// tb_mult_m: directed vectors for mult_m with hand-computed results.
// Inputs change on the falling edge; outputs sampled 1ns after rising.
module tb_mult_m;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    mult_m_if bus ();

    mult_m dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(
        input string        tag,
        input logic [199:0] got,
        input logic [199:0] exp
    );
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int pos(input int i, input int j);
        return 199 - 8 * (5 * i + j);
    endfunction

    function automatic logic [199:0] fill(input logic [7:0] v);
        logic [199:0] m;
        m = '0;
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++)
                m[pos(i, j) -: 8] = v;
        return m;
    endfunction

    function automatic logic [199:0] diag(input logic [7:0] v);
        logic [199:0] m;
        m = '0;
        for (int i = 0; i < 5; i++)
            m[pos(i, i) -: 8] = v;
        return m;
    endfunction

    function automatic logic [199:0] mrow(
        input int          i,
        input logic [39:0] r
    );
        logic [199:0] m;
        m = '0;
        m[pos(i, 0) -: 40] = r;
        return m;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(
        input logic [199:0] a,
        input logic [199:0] b
    );
        @(negedge clk);
        bus.lin = a;
        bus.col = b;
    endtask

    logic [199:0] bm;
    logic [199:0] cm;
    logic [199:0] held;

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        bus.lin  = '0;
        bus.col  = '0;

        // load something non-zero, then reset mid-cycle
        drive(fill(8'h7F), fill(8'h7F));
        step();
        chk("pre_rst_ovf", 200'(bus.ovf), 200'd1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_now_n_out", bus.n_out, '0);
        chk("rst_now_ovf", 200'(bus.ovf), '0);
        for (int t = 0; t < 3; t++) begin
            bus.lin = {7{$urandom()}};
            bus.col = {7{$urandom()}};
            step();
        end
        chk("rst_hold_n_out", bus.n_out, '0);
        chk("rst_hold_ovf", 200'(bus.ovf), '0);
        @(negedge clk);
        rst = 1'b1;

        // identity on the left returns B
        bm = '0;
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++)
                bm[pos(i, j) -: 8] = 8'(i * 37 + j * 11 + 200);
        drive(diag(8'h01), bm);
        step();
        chk("ident_n_out", bus.n_out, bm);
        chk("ident_ovf", 200'(bus.ovf), '0);

        // inputs changed between edges must not move outputs
        bus.lin = fill(8'h7F);
        #2;
        chk("no_edge_hold", bus.n_out, bm);

        // small positive row
        bm = '0;
        bm[pos(0, 0) -: 40] = {8'd2, 8'd1, 8'd1, 8'd2, 8'd2};
        bm[pos(1, 0) -: 40] = {8'd1, 8'd2, 8'd2, 8'd2, 8'd1};
        bm[pos(2, 0) -: 40] = {8'd2, 8'd1, 8'd1, 8'd2, 8'd1};
        bm[pos(3, 0) -: 40] = {8'd3, 8'd3, 8'd0, 8'd1, 8'd3};
        bm[pos(4, 0) -: 40] = {8'd2, 8'd2, 8'd1, 8'd2, 8'd0};
        drive(mrow(0, {8'd1, 8'd2, 8'd3, 8'd4, 8'd2}), bm);
        step();
        cm = mrow(0, {8'd26, 8'd24, 8'd10, 8'd20, 8'd19});
        chk("small_n_out", bus.n_out, cm);
        chk("small_ovf", 200'(bus.ovf), '0);

        // all 0x7F: 80645 per element -> 0x05, overflow
        drive(fill(8'h7F), fill(8'h7F));
        step();
        chk("max_n_out", bus.n_out, fill(8'h05));
        chk("max_ovf", 200'(bus.ovf), 200'd1);

        // all -128 times I: exactly -128, no overflow
        drive(fill(8'h80), diag(8'h01));
        step();
        chk("neg128_n_out", bus.n_out, fill(8'h80));
        chk("neg128_ovf", 200'(bus.ovf), '0);

        // -I times 0x7F: -127 per element
        drive(diag(8'hFF), fill(8'h7F));
        step();
        chk("negi_n_out", bus.n_out, fill(8'h81));
        chk("negi_ovf", 200'(bus.ovf), '0);

        // extreme -128 x -128 sum 81920 = 0x14000 -> 0x00, ovf
        drive(fill(8'h80), fill(8'h80));
        step();
        chk("ext_n_out", bus.n_out, '0);
        chk("ext_ovf", 200'(bus.ovf), 200'd1);

        // single element +127 via 127*1: boundary, no ovf
        drive(diag(8'h7F), diag(8'h01));
        step();
        chk("p127_n_out", bus.n_out, diag(8'h7F));
        chk("p127_ovf", 200'(bus.ovf), '0);

        // ovf is not sticky: drop back to zero
        drive(fill(8'h7F), fill(8'h7F));
        step();
        drive('0, fill(8'h7F));
        step();
        chk("clear_n_out", bus.n_out, '0);
        chk("clear_ovf", 200'(bus.ovf), '0);

        // mid-operation reset pulse between edges
        drive(fill(8'h7F), fill(8'h7F));
        step();
        held = bus.n_out;
        chk("mid_pre", held, fill(8'h05));
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_n_out", bus.n_out, '0);
        chk("mid_rst_ovf", 200'(bus.ovf), '0);
        #1;
        rst = 1'b1;
        step();
        chk("mid_post_n_out", bus.n_out, fill(8'h05));
        chk("mid_post_ovf", 200'(bus.ovf), 200'd1);

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule

// File: doc/mult_m.md
MULT_M -- requirements
Module: mult_m

Interface
REQ-001 Parameters (package constants, not overridable): N=5 (matrix order); W=8 (element width, signed two's complement); ACC_W=18 (dot-product accumulator width).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset; 0 clears all registers immediately.
REQ-004 lin  input  200  left matrix A, 25 signed 8-bit elements, row-major; A(0,0) at [199:192], A(0,1) at [191:184] ... A(4,4) at [7:0].
REQ-005 col  input  200  right matrix B, same packing as lin.
REQ-006 n_out  output  200  registered product C = A x B, same packing; each element C(i,j) is the low 8 bits of the full sum.
REQ-007 ovf  output  1  registered flag; 1 when any C(i,j) full sum lies outside [-128, 127].

Function
REQ-008 C(i,j) SHALL be the sum over k=0..4 of A(i,k)*B(k,j), using signed 16-bit products and an 18-bit signed accumulator; no intermediate truncation.
REQ-009 n_out element (i,j) SHALL be accumulator bits [7:0], wrapping modulo 256 with no saturation.
REQ-010 ovf SHALL be the OR over all 25 elements of (accumulator > 127 or accumulator < -128).
REQ-011 The datapath SHALL be fully combinational from lin/col to the output registers; n_out and ovf SHALL update on every rising clk edge; latency is 1 cycle.
REQ-012 There SHALL be no handshake or enable; inputs are sampled on every edge, and changes to lin/col between edges do not affect outputs until the next edge.
REQ-013 Boundary: -128 x -128 = +16384 SHALL be represented exactly; the extreme sum of 5 x 16384 = 81920 SHALL fit in ACC_W without wrap.
REQ-014 A result of exactly -128 or +127 SHALL NOT set ovf.
REQ-015 ovf SHALL reflect the same edge's n_out; it is not sticky.

Reset
REQ-016 While rst=0: n_out=200'b0 and ovf=0, asynchronously and independent of clk.
REQ-017 Asserting rst mid-operation SHALL discard the current result.
REQ-018 The first rising edge with rst=1 SHALL load the product of the current lin/col.

Structure
REQ-019 Shared package mult_pkg SHALL hold N, W, ACC_W, and an element index/slice helper mapping (i,j) to bit offset (199 - 8*(5*i+j)).
REQ-020 One sub-module, dot5_s8, SHALL compute a 5-term signed 8-bit dot product, returning the 8-bit wrapped result and a per-element overflow bit.
REQ-021 mult_m SHALL instantiate 25 dot5_s8 through generate loops and hold only the output registers.

Verification
REQ-022 Reset: rst=0 with arbitrary lin/col and running clk -> n_out=0, ovf=0 immediately and held until release.
REQ-023 Identity: lin=I (0x01 on the diagonal, 0x00 elsewhere) and col=arbitrary B -> n_out=B one edge later, ovf=0.
REQ-024 Small positive case:
- Stimulus: lin row0=[1,2,3,4,2]; col rows=[2,1,1,2,2],[1,2,2,2,1],[2,1,1,2,1],[3,3,0,1,3],[2,2,1,2,0].
- Response: n_out row0=[26,24,10,20,19], ovf=0.
REQ-025 Overflow: all lin and col elements = 0x7F -> every sum is 80645, every n_out element = 0x05, ovf=1.
REQ-026 Signed boundary:
- lin = all 0x80 (-128), col = I -> every element = 0x80, ovf=0.
- lin = -I (0xFF on the diagonal), col = all 0x7F -> every element = 0x81 (-127), ovf=0.
REQ-027 Mid-operation reset: load the overflow vector, pulse rst=0 between edges -> outputs clear at once; after release, the next edge restores 0x05 elements and ovf=1.
